chan_arb16: RTL and testbench

//  Round-robin arbiter between the 16 per-channel processors (prc1chan req/ack/dout) and GTP TX lane 0.

---
 rtl/chan_arb16_pkg.sv | 35 +++
 rtl/chan_arb16_if.sv | 27 ++
 rtl/chan_arb16_rr.sv | 26 ++
 rtl/chan_arb16.sv | 140 ++++++++++++++
 tb/tb_chan_arb16.sv | 375 +++++++++++++++++++++++++++++++++++++
 5 files changed

// File: rtl/chan_arb16_pkg.sv
// Shared constants, GTP 8b/10b control words and FSM encodings for the chan_arb16 arbiter.
package chan_arb16_pkg;

    localparam int unsigned NCH   = 16;
    localparam int unsigned DW    = 16;
    localparam int unsigned PTR_W = 4;
    localparam int unsigned LEN_W = 10;
    localparam int unsigned GAP_W = 3;
    localparam int unsigned OVF_W = 8;
    localparam int unsigned BLK_W = 32;

    localparam logic [7:0]    K28_5   = 8'hBC;
    localparam logic [7:0]    K28_3   = 8'h7C;
    localparam logic [DW-1:0] COMMA_W = {8'h50, K28_5};

    typedef enum logic [1:0] {
        ST_IDLE   = 2'd0,
        ST_GRANT  = 2'd1,
        ST_STREAM = 2'd2,
        ST_GAP    = 2'd3
    } arb_state_e;

    // One GTP lane-0 word plus its charisk flag for the low byte
    typedef struct packed {
        logic [DW-1:0] data;
        logic          k;
    } gtp_word_t;

    localparam gtp_word_t COMMA_WORD = '{data: COMMA_W, k: 1'b1};

    function automatic gtp_word_t trig_word(input logic [7:0] tag);
        return '{data: {tag, K28_3}, k: 1'b1};
    endfunction

endpackage

// File: rtl/chan_arb16_if.sv
// Channel-side and GTP-side signal bundle of the chan_arb16 arbiter.
interface chan_arb16_if;
    import chan_arb16_pkg::*;

    logic [NCH*DW-1:0] din;
    logic [NCH-1:0]    req;
    logic [NCH-1:0]    ack;
    logic [NCH-1:0]    en_mask;
    logic              trig;
    logic [7:0]        trig_tag;
    logic [DW-1:0]     gtp_data;
    logic              gtp_k;
    logic              busy;
    logic [OVF_W-1:0]  ovf_cnt;
    logic [BLK_W-1:0]  blk_cnt;

    modport master (
        output din, req, en_mask, trig, trig_tag,
        input  ack, gtp_data, gtp_k, busy, ovf_cnt, blk_cnt
    );

    modport slave (
        input  din, req, en_mask, trig, trig_tag,
        output ack, gtp_data, gtp_k, busy, ovf_cnt, blk_cnt
    );

endinterface

// File: rtl/chan_arb16_rr.sv
// Combinational round-robin picker: first eligible requester at or after ptr, wrapping 15->0.
module chan_arb16_rr
    import chan_arb16_pkg::*;
(
    input  logic [NCH-1:0]   req,
    input  logic [PTR_W-1:0] ptr,
    output logic [PTR_W-1:0] sel_c,
    output logic             any_c
);

    logic [PTR_W-1:0] idx;

    always_comb begin
        sel_c = '0;
        any_c = 1'b0;
        idx   = '0;
        for (int i = 0; i < int'(NCH); i++) begin
            idx = ptr + PTR_W'(i);
            if (!any_c && req[idx]) begin
                sel_c = idx;
                any_c = 1'b1;
            end
        end
    end

endmodule

// File: rtl/chan_arb16.sv
// Round-robin block arbiter from 16 channel processors onto GTP lane 0 with comma fill and trigger K-words.
// Define CHAN_ARB_CNT_EN to build the 32-bit completed-block counter; otherwise blk_cnt reads 0.
module chan_arb16
    import chan_arb16_pkg::*;
#(
    parameter int unsigned MAXLEN = 1023,
    parameter int unsigned GAPLEN = 1
)
(
    input  logic        clk,
    input  logic        rst,
    chan_arb16_if.slave bus
);

    arb_state_e       state, state_nx;
    logic [PTR_W-1:0] sel, sel_nx;
    logic [PTR_W-1:0] ptr, ptr_nx;
    logic [LEN_W-1:0] len, len_nx;
    logic [GAP_W-1:0] gap, gap_nx;
    gtp_word_t        out_q, out_nx;
    logic [OVF_W-1:0] ovf, ovf_nx;
    logic             busy_q;
    logic [NCH-1:0]   ack_c;

    logic [NCH-1:0]   req_elig_c;
    logic [PTR_W-1:0] pick_sel_c;
    logic             pick_any_c;
    logic [7:0]       din_base;
    logic [DW-1:0]    word_c;

    assign req_elig_c = bus.req & bus.en_mask;
    assign din_base   = {sel, 4'b0000};
    assign word_c     = bus.din[din_base +: DW];

    chan_arb16_rr u_rr (
        .req   (req_elig_c),
        .ptr   (ptr),
        .sel_c (pick_sel_c),
        .any_c (pick_any_c)
    );

    always_ff @(posedge clk) begin
        if (rst) begin
            state  <= ST_IDLE;
            sel    <= '0;
            ptr    <= '0;
            len    <= '0;
            gap    <= '0;
            out_q  <= COMMA_WORD;
            ovf    <= '0;
            busy_q <= 1'b0;
        end else begin
            state  <= state_nx;
            sel    <= sel_nx;
            ptr    <= ptr_nx;
            len    <= len_nx;
            gap    <= gap_nx;
            out_q  <= out_nx;
            ovf    <= ovf_nx;
            busy_q <= (state_nx == ST_STREAM);
        end
    end

    // A trig cycle freezes the whole FSM and only swaps the outgoing word for the K28.3 trigger word
    always_comb begin
        state_nx = state;
        sel_nx   = sel;
        ptr_nx   = ptr;
        len_nx   = len;
        gap_nx   = gap;
        out_nx   = COMMA_WORD;
        ovf_nx   = ovf;
        ack_c    = '0;
        if (bus.trig) begin
            out_nx = trig_word(bus.trig_tag);
        end else begin
            unique case (state)
                ST_IDLE: begin
                    if (pick_any_c) state_nx = ST_GRANT;
                end
                ST_GRANT: begin
                    if (pick_any_c) begin
                        sel_nx   = pick_sel_c;
                        ptr_nx   = pick_sel_c + PTR_W'(1);
                        len_nx   = '0;
                        state_nx = ST_STREAM;
                    end else begin
                        state_nx = ST_IDLE;
                    end
                end
                ST_STREAM: begin
                    if (len == LEN_W'(MAXLEN)) begin
                        state_nx = ST_GAP;
                        gap_nx   = '0;
                        if (ovf != '1) ovf_nx = ovf + OVF_W'(1);
                    end else begin
                        ack_c[sel] = 1'b1;
                        if (bus.req[sel]) begin
                            out_nx = '{data: word_c, k: 1'b0};
                            len_nx = len + LEN_W'(1);
                        end else begin
                            state_nx = ST_GAP;
                            gap_nx   = '0;
                        end
                    end
                end
                ST_GAP: begin
                    if (gap == GAP_W'(GAPLEN - 1)) state_nx = ST_IDLE;
                    else                           gap_nx   = gap + GAP_W'(1);
                end
                default: state_nx = ST_IDLE;
            endcase
        end
    end

    assign bus.ack      = ack_c;
    assign bus.gtp_data = out_q.data;
    assign bus.gtp_k    = out_q.k;
    assign bus.busy     = busy_q;
    assign bus.ovf_cnt  = ovf;

`ifdef CHAN_ARB_CNT_EN
    logic [BLK_W-1:0] blk_q;

    // Counts blocks ending either by req dropping or by the MAXLEN limit
    always_ff @(posedge clk) begin
        if (rst) begin
            blk_q <= '0;
        end else if (state == ST_STREAM && !bus.trig &&
                     (len == LEN_W'(MAXLEN) || !bus.req[sel])) begin
            blk_q <= blk_q + BLK_W'(1);
        end
    end

    assign bus.blk_cnt = blk_q;
`else
    assign bus.blk_cnt = '0;
`endif

endmodule

// File: tb/tb_chan_arb16.sv
// Directed self-checking bench for chan_arb16 (built with MAXLEN=8, GAPLEN=1).
module tb_chan_arb16;

    logic clk = 1'b0;
    logic rst;

    always #5 clk = ~clk;

    chan_arb16_if bus ();

    chan_arb16 #(.MAXLEN(8), .GAPLEN(1)) dut (
        .clk (clk),
        .rst (rst),
        .bus (bus)
    );

    localparam logic [15:0] COMMA = 16'h50BC;
`ifdef CHAN_ARB_CNT_EN
    localparam int CNT_ON = 1;
`else
    localparam int CNT_ON = 0;
`endif

    int n_tests = 0;
    int n_fail  = 0;
    int blk_owner[8];
    int blk_len[8];
    int blk_seen;

    task automatic tick;
        @(posedge clk);
        #1;
    endtask

    task automatic set_word(input int ch, input logic [15:0] v);
        bus.din[16*ch +: 16] = v;
    endtask

    task automatic do_reset;
        rst          = 1'b1;
        bus.req      = '0;
        bus.trig     = 1'b0;
        bus.trig_tag = '0;
        bus.en_mask  = '1;
        bus.din      = '0;
        tick;
        tick;
        rst = 1'b0;
        #1;
    endtask

    // Records owner and consumed-word count of successive blocks until the n-th block starts
    task automatic run_blocks(input int n);
        logic [15:0] a, prev;
        prev     = '0;
        blk_seen = 0;
        for (int k = 0; k < 8; k++) begin
            blk_owner[k] = -1;
            blk_len[k]   = 0;
        end
        #1;
        for (int t = 0; t < 400 && blk_seen < n; t++) begin
            a = bus.ack & bus.req;
            if (a != 16'h0 && prev == 16'h0) begin
                for (int b = 0; b < 16; b++) if (a[b]) blk_owner[blk_seen] = b;
                blk_seen++;
            end
            if (a != 16'h0 && blk_seen > 0) blk_len[blk_seen-1]++;
            prev = a;
            if (blk_seen < n) tick;
        end
    endtask

    task automatic test_reset;
        rst = 1'b1;
        bus.req = '0; bus.trig = 1'b0; bus.trig_tag = '0; bus.en_mask = '1; bus.din = '0;
        tick;
        n_tests++;
        if (bus.gtp_data !== COMMA || bus.gtp_k !== 1'b1 || bus.ack !== 16'h0 || bus.busy !== 1'b0) begin
            n_fail++;
            $display("FAIL reset_outputs: data=%h k=%b ack=%h busy=%b, want %h k=1 ack=0 busy=0",
                     bus.gtp_data, bus.gtp_k, bus.ack, bus.busy, COMMA);
        end
        n_tests++;
        if (bus.ovf_cnt !== 8'h0 || bus.blk_cnt !== 32'h0) begin
            n_fail++;
            $display("FAIL reset_counters: ovf=%0d blk=%0d, want 0 0", bus.ovf_cnt, bus.blk_cnt);
        end
        rst = 1'b0;
        for (int c = 0; c < 4; c++) begin
            tick;
            n_tests++;
            if (bus.gtp_data !== COMMA || bus.gtp_k !== 1'b1 || bus.ack !== 16'h0) begin
                n_fail++;
                $display("FAIL idle_comma cyc%0d: data=%h k=%b ack=%h, want %h k=1 ack=0",
                         c, bus.gtp_data, bus.gtp_k, bus.ack, COMMA);
            end
        end
    endtask

    task automatic test_single_block;
        logic [15:0] w[4];
        int waited;
        w[0] = 16'hA0A0; w[1] = 16'hA1A1; w[2] = 16'hA2A2; w[3] = 16'hA3A3;
        do_reset;
        set_word(3, w[0]);
        bus.req[3] = 1'b1;
        #1;
        waited = 0;
        while (bus.ack[3] !== 1'b1 && waited < 10) begin
            tick;
            waited++;
        end
        n_tests++;
        if (waited != 2) begin
            n_fail++;
            $display("FAIL grant_latency: ack after %0d cycles, want 2", waited);
        end
        for (int i = 0; i < 4; i++) begin
            n_tests++;
            if (bus.ack !== 16'h0008) begin
                n_fail++;
                $display("FAIL blk_ack word%0d: ack=%h, want 0008", i, bus.ack);
            end
            tick;
            n_tests++;
            if (bus.gtp_data !== w[i] || bus.gtp_k !== 1'b0 || bus.busy !== 1'b1) begin
                n_fail++;
                $display("FAIL blk_word%0d: data=%h k=%b busy=%b, want %h k=0 busy=1",
                         i, bus.gtp_data, bus.gtp_k, bus.busy, w[i]);
            end
            if (i < 3) set_word(3, w[i+1]);
            else       bus.req[3] = 1'b0;
            #1;
        end
        tick;
        n_tests++;
        if (bus.gtp_data !== COMMA || bus.gtp_k !== 1'b1 || bus.blk_cnt !== 32'(CNT_ON)) begin
            n_fail++;
            $display("FAIL blk_end: data=%h k=%b blk=%0d, want %h k=1 blk=%0d",
                     bus.gtp_data, bus.gtp_k, bus.blk_cnt, COMMA, CNT_ON);
        end
        tick;
        n_tests++;
        if (bus.ack !== 16'h0 || bus.busy !== 1'b0 || bus.ovf_cnt !== 8'h0) begin
            n_fail++;
            $display("FAIL blk_after: ack=%h busy=%b ovf=%0d, want 0 0 0", bus.ack, bus.busy, bus.ovf_cnt);
        end
    endtask

    task automatic test_round_robin;
        do_reset;
        set_word(0, 16'h0C00);
        set_word(15, 16'h0C0F);
        bus.req = 16'h8001;
        run_blocks(4);
        n_tests++;
        if (blk_seen != 4 || blk_owner[0] != 0 || blk_owner[1] != 15 || blk_owner[2] != 0 || blk_owner[3] != 15) begin
            n_fail++;
            $display("FAIL rr_order: seen=%0d owners=%0d,%0d,%0d,%0d, want 4 blocks 0,15,0,15",
                     blk_seen, blk_owner[0], blk_owner[1], blk_owner[2], blk_owner[3]);
        end
        n_tests++;
        if (blk_len[0] != 8 || blk_len[1] != 8 || blk_len[2] != 8) begin
            n_fail++;
            $display("FAIL rr_len: lens=%0d,%0d,%0d, want 8,8,8", blk_len[0], blk_len[1], blk_len[2]);
        end
        n_tests++;
        if (bus.ovf_cnt !== 8'd3 || bus.blk_cnt !== 32'(3*CNT_ON)) begin
            n_fail++;
            $display("FAIL rr_counters: ovf=%0d blk=%0d, want 3 %0d", bus.ovf_cnt, bus.blk_cnt, 3*CNT_ON);
        end
        do_reset;
        bus.en_mask = 16'h7FFF;
        set_word(0, 16'h0C00);
        bus.req = 16'h8001;
        run_blocks(3);
        n_tests++;
        if (blk_seen != 3 || blk_owner[0] != 0 || blk_owner[1] != 0 || blk_owner[2] != 0) begin
            n_fail++;
            $display("FAIL rr_masked: seen=%0d owners=%0d,%0d,%0d, want 3 blocks 0,0,0",
                     blk_seen, blk_owner[0], blk_owner[1], blk_owner[2]);
        end
    endtask

    task automatic test_trig_idle;
        do_reset;
        bus.trig_tag = 8'h5A;
        bus.trig     = 1'b1;
        tick;
        bus.trig = 1'b0;
        n_tests++;
        if (bus.gtp_data !== 16'h5A7C || bus.gtp_k !== 1'b1) begin
            n_fail++;
            $display("FAIL trig_idle: data=%h k=%b, want 5a7c k=1", bus.gtp_data, bus.gtp_k);
        end
        tick;
        n_tests++;
        if (bus.gtp_data !== COMMA || bus.gtp_k !== 1'b1) begin
            n_fail++;
            $display("FAIL trig_idle_after: data=%h k=%b, want %h k=1", bus.gtp_data, bus.gtp_k, COMMA);
        end
    endtask

    task automatic test_trig_stream;
        logic [15:0] w[6];
        int waited;
        for (int i = 0; i < 6; i++) w[i] = 16'hB000 + 16'(i);
        do_reset;
        set_word(3, w[0]);
        bus.req[3] = 1'b1;
        #1;
        waited = 0;
        while (bus.ack[3] !== 1'b1 && waited < 10) begin
            tick;
            waited++;
        end
        for (int i = 0; i < 6; i++) begin
            if (i == 1) bus.en_mask[3] = 1'b0;
            if (i == 2) begin
                bus.trig_tag = 8'hA5;
                bus.trig     = 1'b1;
                #1;
                n_tests++;
                if (bus.ack !== 16'h0) begin
                    n_fail++;
                    $display("FAIL trig_ack_low: ack=%h, want 0000", bus.ack);
                end
                tick;
                bus.trig = 1'b0;
                n_tests++;
                if (bus.gtp_data !== 16'hA57C || bus.gtp_k !== 1'b1) begin
                    n_fail++;
                    $display("FAIL trig_word: data=%h k=%b, want a57c k=1", bus.gtp_data, bus.gtp_k);
                end
                #1;
            end
            if (i == 4) begin
                bus.trig_tag = 8'h11;
                bus.trig     = 1'b1;
                tick;
                bus.trig_tag = 8'h22;
                n_tests++;
                if (bus.gtp_data !== 16'h117C || bus.gtp_k !== 1'b1) begin
                    n_fail++;
                    $display("FAIL trig_b2b_1: data=%h k=%b, want 117c k=1", bus.gtp_data, bus.gtp_k);
                end
                tick;
                bus.trig = 1'b0;
                n_tests++;
                if (bus.gtp_data !== 16'h227C || bus.gtp_k !== 1'b1) begin
                    n_fail++;
                    $display("FAIL trig_b2b_2: data=%h k=%b, want 227c k=1", bus.gtp_data, bus.gtp_k);
                end
                #1;
            end
            n_tests++;
            if (bus.ack !== 16'h0008) begin
                n_fail++;
                $display("FAIL trig_stream_ack word%0d: ack=%h, want 0008", i, bus.ack);
            end
            tick;
            n_tests++;
            if (bus.gtp_data !== w[i] || bus.gtp_k !== 1'b0) begin
                n_fail++;
                $display("FAIL trig_stream_word%0d: data=%h k=%b, want %h k=0", i, bus.gtp_data, bus.gtp_k, w[i]);
            end
            if (i < 5) set_word(3, w[i+1]);
            else       bus.req[3] = 1'b0;
            #1;
        end
        tick;
        n_tests++;
        if (bus.gtp_data !== COMMA || bus.gtp_k !== 1'b1 || bus.ovf_cnt !== 8'h0 || bus.blk_cnt !== 32'(CNT_ON)) begin
            n_fail++;
            $display("FAIL trig_stream_end: data=%h k=%b ovf=%0d blk=%0d, want %h k=1 ovf=0 blk=%0d",
                     bus.gtp_data, bus.gtp_k, bus.ovf_cnt, bus.blk_cnt, COMMA, CNT_ON);
        end
    endtask

    task automatic test_maxlen;
        do_reset;
        set_word(5, 16'h0505);
        set_word(9, 16'h0909);
        bus.req[5] = 1'b1;
        run_blocks(1);
        n_tests++;
        if (blk_seen != 1 || blk_owner[0] != 5) begin
            n_fail++;
            $display("FAIL maxlen_grant: seen=%0d owner=%0d, want 1 block on 5", blk_seen, blk_owner[0]);
        end
        for (int i = 0; i < 8; i++) tick;
        n_tests++;
        if (bus.ack !== 16'h0 || bus.gtp_data !== 16'h0505 || bus.gtp_k !== 1'b0) begin
            n_fail++;
            $display("FAIL maxlen_ack_drop: ack=%h data=%h k=%b, want 0000 0505 k=0",
                     bus.ack, bus.gtp_data, bus.gtp_k);
        end
        tick;
        n_tests++;
        if (bus.ovf_cnt !== 8'd1 || bus.busy !== 1'b0 || bus.gtp_data !== COMMA) begin
            n_fail++;
            $display("FAIL maxlen_ovf: ovf=%0d busy=%b data=%h, want 1 0 %h",
                     bus.ovf_cnt, bus.busy, bus.gtp_data, COMMA);
        end
        bus.req[9] = 1'b1;
        run_blocks(2);
        n_tests++;
        if (blk_seen != 2 || blk_owner[0] != 9 || blk_owner[1] != 5 || blk_len[0] != 8) begin
            n_fail++;
            $display("FAIL maxlen_regrant: seen=%0d owners=%0d,%0d len0=%0d, want 2 blocks 9,5 len 8",
                     blk_seen, blk_owner[0], blk_owner[1], blk_len[0]);
        end
        n_tests++;
        if (bus.ovf_cnt !== 8'd2) begin
            n_fail++;
            $display("FAIL maxlen_ovf2: ovf=%0d, want 2", bus.ovf_cnt);
        end
    endtask

    task automatic test_rst_mid_block;
        do_reset;
        set_word(5, 16'h0505);
        set_word(7, 16'h0707);
        bus.req[5] = 1'b1;
        run_blocks(2);
        tick;
        tick;
        n_tests++;
        if (blk_seen != 2 || bus.ovf_cnt !== 8'd1 || bus.ack !== 16'h0020) begin
            n_fail++;
            $display("FAIL rst_pre: seen=%0d ovf=%0d ack=%h, want 2 1 0020", blk_seen, bus.ovf_cnt, bus.ack);
        end
        rst = 1'b1;
        tick;
        rst = 1'b0;
        n_tests++;
        if (bus.ack !== 16'h0 || bus.gtp_data !== COMMA || bus.gtp_k !== 1'b1 || bus.busy !== 1'b0) begin
            n_fail++;
            $display("FAIL rst_mid_outputs: ack=%h data=%h k=%b busy=%b, want 0000 %h k=1 busy=0",
                     bus.ack, bus.gtp_data, bus.gtp_k, bus.busy, COMMA);
        end
        n_tests++;
        if (bus.ovf_cnt !== 8'h0 || bus.blk_cnt !== 32'h0) begin
            n_fail++;
            $display("FAIL rst_mid_counters: ovf=%0d blk=%0d, want 0 0", bus.ovf_cnt, bus.blk_cnt);
        end
        bus.req[7] = 1'b1;
        run_blocks(1);
        n_tests++;
        if (blk_seen != 1 || blk_owner[0] != 5) begin
            n_fail++;
            $display("FAIL rst_mid_ptr: seen=%0d owner=%0d, want block on 5", blk_seen, blk_owner[0]);
        end
    endtask

    initial begin
        #500000;
        $display("FAIL watchdog: time limit reached, tests=%0d", n_tests);
        $fatal(1, "watchdog expired");
    end

    initial begin
        test_reset;
        test_single_block;
        test_round_robin;
        test_trig_idle;
        test_trig_stream;
        test_maxlen;
        test_rst_mid_block;
        $display("[TB] %0d tests run, %0d failed", n_tests, n_fail);
        $finish;
    end

endmodule
